imem_loader: RTL
================

# imem_loader

Boot-time writer for the instruction memory. Receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them to consecutive word addresses starting at 0. This matches the program counter's reset value and its +1-per-word stepping. Holds the processor in reset until the image is fully written.

## Interface
Parameters:
- DEPTH, 1001: number of 32-bit words in instruction memory (indices 0..DEPTH-1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; restarts a load when in DONE, ignored in all other states.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  word address of write.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  drives processor/program-counter reset; high while loading.
- done  output  1  load finished (success or error).
- err  output  1  header word count exceeded DEPTH.

## Operation
- Byte accepted on a posedge where in_valid && in_ready.
- Words are big-endian: the first accepted byte of each group of 4 is bits [31:24], the fourth is [7:0].
- Stream format: a header word N (word count), then N instruction words.
- States:
  - HDR: in_ready=1. Collects 4 bytes into N.
    - N==0 -> FLUSH.
    - N>DEPTH -> err=1, -> FLUSH, no writes.
    - Otherwise -> DATA, with word index cleared to 0.
  - DATA: in_ready=1. Each completed word is issued as a write to address = word index, then the index increments. The write that completes word N-1 -> FLUSH.
  - FLUSH: in_ready=0. Lasts one cycle, so the final write lands in memory. -> DONE.
  - DONE: in_ready=0. done=1. cpu_hold=err (the processor stays held if the image was rejected). start -> HDR, which clears err, done, the byte counter and the word index, and sets cpu_hold=1.
- Write path is registered:
  - wr_addr and wr_data hold their last values when wr_en=0.
  - wr_addr is zero-extended from the word index; the index never exceeds DEPTH-1.
- Byte counter is 2 bits and wraps 3->0 on each word completion. The word index is 32 bits and never wraps in legal operation.
- in_valid while in_ready=0: no effect. The byte is not consumed, and the upstream holds it.

## Timing
- Reset values: state=HDR, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0, byte counter=0, word index=0.
- Reset asserted mid-load:
  - Outputs go to their reset values immediately (asynchronously).
  - A partially assembled word is discarded.
  - Memory words already written are not altered.
  - After reset, the loader expects a new header.
- Write latency: 4th byte of a word accepted at edge k -> wr_en=1 during cycle k..k+1, and memory captures at edge k+1.
- Throughput: one byte per cycle sustained; back-to-back words give wr_en high one cycle in every four.
- Completion: last byte accepted at edge k.
  - Edge k: state=FLUSH, wr_en=1.
  - Edge k+1: state=DONE, done=1, cpu_hold=0.
  - The processor's first fetch of address 0 occurs no earlier than edge k+2.
- Header error or N==0: 4th header byte at edge k -> FLUSH at k, DONE at k+1, no wr_en pulses.
- start asserted in the same cycle as a transition into DONE is ignored; it is honoured only while already in DONE.

## Test plan
- Reset then stream 00 00 00 02, 12 34 56 78, DE AD BE EF, one byte per cycle -> two wr_en pulses: (addr 0, 0x12345678), then (addr 1, 0xDEADBEEF). done=1 and cpu_hold=0 two edges after the last byte.
- Same stream with in_valid toggling 1/0 every cycle -> identical writes and data; wr_en never asserted between partial bytes; no bytes lost or duplicated.
- Header 00 00 03 EA (1002) -> err=1, done=1, cpu_hold=1, zero writes, in_ready=0 afterwards.
- Header 00 00 00 00 -> no writes; done=1 and cpu_hold=0 two edges after the 4th byte.
- Assert rst after 6 bytes of a 3-word image -> outputs immediately at reset values, no write for the partial word. A fresh 1-word image then writes address 0.
- After a completed load, pulse start and send a 1-word image AA BB CC DD -> err and done cleared, cpu_hold=1 during the load, then write (addr 0, 0xAABBCCDD), done=1 and cpu_hold=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte stream
// (header word count, then N words) and writes them to word addresses 0..N-1.
module imem_loader #(
  parameter int unsigned DEPTH = 1001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StHdr, StData, StFlush, StDone} state_e;

  localparam logic [31:0] DepthW = 32'(DEPTH);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] count_q, count_d;
  logic [31:0] idx_q, idx_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;

  logic        accept;
  logic        word_done;
  logic [31:0] word;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    idx_d      = idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;

    in_ready  = (state_q == StHdr) || (state_q == StData);
    accept    = in_valid && in_ready;
    word      = {shift_q, in_data};
    word_done = accept && (byte_cnt_q == 2'd3);

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], in_data};
    end

    unique case (state_q)
      StHdr: begin
        if (word_done) begin
          if (word == 32'd0) begin
            state_d = StFlush;
          end else if (word > DepthW) begin
            // Oversized image: reject without touching memory
            err_d   = 1'b1;
            state_d = StFlush;
          end else begin
            count_d = word;
            idx_d   = 32'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = word;
          idx_d     = idx_q + 32'd1;
          if (idx_q == count_q - 32'd1) begin
            state_d = StFlush;
          end
        end
      end
      // One extra cycle lets the last registered write land before release
      StFlush: begin
        state_d = StDone;
      end
      StDone: begin
        if (start) begin
          state_d    = StHdr;
          err_d      = 1'b0;
          byte_cnt_d = 2'd0;
          idx_d      = 32'd0;
        end
      end
      default: begin
        state_d = StHdr;
      end
    endcase

    done     = (state_q == StDone);
    cpu_hold = (state_q != StDone) || err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHdr;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      count_q    <= 32'd0;
      idx_q      <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

endmodule
